// File: rtl/alu_unit.sv
// 4-bit registered ALU: 16 operations on {op, a, b}, result plus C/Z/N/V flags
// registered one cycle after in_valid; outputs hold while in_valid is low.
module alu_unit #(
    parameter int DW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [3*DW-1:0] in,
    output logic [DW-1:0]   sum,
    output logic            out_valid,
    output logic            carry,
    output logic            zero,
    output logic            negative,
    output logic            overflow
);
    localparam int SW = $clog2(DW);
    localparam int M  = DW - 1;
    localparam logic [DW:0] ONE = (DW+1)'(1);

    logic [DW-1:0] w_op;
    logic [DW-1:0] w_a;
    logic [DW-1:0] w_b;
    logic [SW-1:0] w_s;
    logic [DW:0]   w_add;
    logic [DW:0]   w_sub;
    logic [DW:0]   w_inc;
    logic [DW:0]   w_dec;
    logic [DW:0]   w_shl;
    logic [DW:0]   w_shr;
    logic [DW-1:0] w_sar;
    logic [DW-1:0] w_rol;
    logic [DW-1:0] w_ror;
    logic          w_slt;
    logic [DW-1:0] w_res;
    logic          w_cy;
    logic          w_ov;

    logic [DW-1:0] r_sum;
    logic          r_vld;
    logic          r_cy;
    logic          r_z;
    logic          r_n;
    logic          r_ov;

    assign {w_op, w_a, w_b} = in;
    assign w_s = w_b[SW-1:0];

    // The extra MSB of each add/sub result is the carry-out or borrow.
    assign w_add = {1'b0, w_a} + {1'b0, w_b};
    assign w_sub = {1'b0, w_a} - {1'b0, w_b};
    assign w_inc = {1'b0, w_a} + ONE;
    assign w_dec = {1'b0, w_a} - ONE;

    // A guard bit beside a catches the last bit shifted out (0 when s=0).
    assign w_shl = {1'b0, w_a} << w_s;
    assign w_shr = {w_a, 1'b0} >> w_s;
    assign w_sar = $signed(w_a) >>> w_s;
    assign w_slt = $signed(w_a) < $signed(w_b);

    always_comb begin
        w_rol = '0;
        w_ror = '0;
        for (int i = 0; i < DW; i++) begin
            w_rol[i] = w_a[SW'(i) - w_s];
            w_ror[i] = w_a[SW'(i) + w_s];
        end
    end

    always_comb begin
        w_res = '0;
        w_cy  = 1'b0;
        w_ov  = 1'b0;
        case (w_op)
            4'h0: begin
                {w_cy, w_res} = w_add;
                w_ov = (w_a[M] == w_b[M]) && (w_add[M] != w_a[M]);
            end
            4'h1: begin
                {w_cy, w_res} = w_sub;
                w_ov = (w_a[M] != w_b[M]) && (w_sub[M] != w_a[M]);
            end
            4'h2: w_res = w_a & w_b;
            4'h3: w_res = w_a | w_b;
            4'h4: w_res = w_a ^ w_b;
            4'h5: w_res = ~(w_a | w_b);
            4'h6: w_res = ~(w_a & w_b);
            4'h7: w_res = ~(w_a ^ w_b);
            4'h8: {w_cy, w_res} = w_shl;
            4'h9: {w_res, w_cy} = w_shr;
            4'hA: begin
                w_res = w_sar;
                w_cy  = w_shr[0];
            end
            4'hB: w_res = w_rol;
            4'hC: w_res = w_ror;
            4'hD: begin
                {w_cy, w_res} = w_inc;
                w_ov = ~w_a[M] & w_inc[M];
            end
            4'hE: begin
                {w_cy, w_res} = w_dec;
                w_ov = w_a[M] & ~w_dec[M];
            end
            default: w_res = {{(DW-1){1'b0}}, w_slt};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum <= '0;
            r_vld <= 1'b0;
            r_cy  <= 1'b0;
            r_z   <= 1'b0;
            r_n   <= 1'b0;
            r_ov  <= 1'b0;
        end else if (in_valid) begin
            r_sum <= w_res;
            r_vld <= 1'b1;
            r_cy  <= w_cy;
            r_z   <= (w_res == '0);
            r_n   <= w_res[M];
            r_ov  <= w_ov;
        end else begin
            r_vld <= 1'b0;
        end
    end

    assign sum       = r_sum;
    assign out_valid = r_vld;
    assign carry     = r_cy;
    assign zero      = r_z;
    assign negative  = r_n;
    assign overflow  = r_ov;
endmodule

// File: tb/tb_alu_unit.sv
// Bench for alu_unit: directed literal checks plus randomized traffic compared
// every cycle against an integer-arithmetic reference model.
module tb_alu_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [11:0] in_dat;
    logic [3:0]  sum;
    logic        out_valid;
    logic        carry;
    logic        zero;
    logic        negative;
    logic        overflow;

    int n_chk  = 0;
    int n_pass = 0;

    logic [3:0] e_sum;
    logic       e_vld, e_c, e_z, e_n, e_o;
    logic       seen_rst = 1'b0;

    alu_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in       (in_dat),
        .sum      (sum),
        .out_valid(out_valid),
        .carry    (carry),
        .zero     (zero),
        .negative (negative),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Returns {carry, overflow, result} from plain integer arithmetic.
    function automatic logic [5:0] ref_alu(input int op, input int a, input int b);
        int r, c, o, sa, sb, s, t;
        sa = (a > 7) ? a - 16 : a;
        sb = (b > 7) ? b - 16 : b;
        s  = b % 4;
        r = 0; c = 0; o = 0;
        case (op)
            0:  begin t = a + b; r = t % 16; c = (t > 15); o = (sa + sb > 7) || (sa + sb < -8); end
            1:  begin t = a - b; r = (t + 16) % 16; c = (a < b); o = (sa - sb > 7) || (sa - sb < -8); end
            2:  r = a & b;
            3:  r = a | b;
            4:  r = a ^ b;
            5:  r = 15 - (a | b);
            6:  r = 15 - (a & b);
            7:  r = 15 - (a ^ b);
            8:  begin r = (a << s) % 16; c = (s == 0) ? 0 : (a >> (4 - s)) % 2; end
            9:  begin r = a >> s; c = (s == 0) ? 0 : (a >> (s - 1)) % 2; end
            10: begin r = (sa >>> s) & 15; c = (s == 0) ? 0 : (a >> (s - 1)) % 2; end
            11: r = ((a << s) | (a >> (4 - s))) % 16;
            12: r = ((a >> s) | (a << (4 - s))) % 16;
            13: begin r = (a + 1) % 16; c = (a == 15); o = (a == 7); end
            14: begin r = (a + 15) % 16; c = (a == 0); o = (a == 8); end
            default: r = (sa < sb) ? 1 : 0;
        endcase
        return {c[0], o[0], r[3:0]};
    endfunction

    task automatic check(input string nm, input logic [8:0] got, input logic [8:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got {sum,v,c,z,n,o}=%b required %b at %0t", nm, got, exp, $time);
    endtask

    task automatic lit(input string nm, input logic [3:0] s, input logic v, input logic c,
                       input logic z, input logic n, input logic o);
        check(nm, {sum, out_valid, carry, zero, negative, overflow}, {s, v, c, z, n, o});
    endtask

    task automatic drive(input logic v, input logic [11:0] d);
        in_valid = v;
        in_dat   = d;
        @(negedge clk);
    endtask

    // Reference state: what the registered outputs must be after each edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            e_sum = 4'h0; e_vld = 1'b0; e_c = 1'b0; e_z = 1'b0; e_n = 1'b0; e_o = 1'b0;
            seen_rst = 1'b1;
        end else if (in_valid) begin
            {e_c, e_o, e_sum} = ref_alu(int'(in_dat[11:8]), int'(in_dat[7:4]), int'(in_dat[3:0]));
            e_vld = 1'b1;
            e_z   = (e_sum == 4'h0);
            e_n   = e_sum[3];
        end else begin
            e_vld = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (seen_rst)
            check("cycle", {sum, out_valid, carry, zero, negative, overflow},
                  {e_sum, e_vld, e_c, e_z, e_n, e_o});
    end

    initial begin
        check("ref_sub", {3'b0, ref_alu(1, 3, 5)},  {3'b0, 6'b10_1110});
        check("ref_sar", {3'b0, ref_alu(10, 9, 1)}, {3'b0, 6'b10_1100});
        check("ref_add", {3'b0, ref_alu(0, 7, 1)},  {3'b0, 6'b01_1000});
        check("ref_dec", {3'b0, ref_alu(14, 0, 0)}, {3'b0, 6'b10_1111});

        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_dat   = 12'hFFF;
        repeat (2) @(negedge clk);
        lit("reset", 4'h0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        drive(1'b1, 12'h00B); lit("add_b",  4'hB, 1, 0, 0, 1, 0);
        drive(1'b1, 12'h005); lit("add_5",  4'h5, 1, 0, 0, 0, 0);
        drive(1'b1, 12'h000); lit("add_0",  4'h0, 1, 0, 1, 0, 0);
        drive(1'b1, 12'h071); lit("add_ov", 4'h8, 1, 0, 0, 1, 1);
        drive(1'b1, 12'h135); lit("sub_bw", 4'hE, 1, 1, 0, 1, 0);
        drive(1'b1, 12'hA91); lit("sar",    4'hC, 1, 1, 0, 1, 0);
        drive(1'b1, 12'hB91); lit("rol",    4'h3, 1, 0, 0, 0, 0);
        drive(1'b1, 12'h8F2); lit("shl",    4'hC, 1, 1, 0, 1, 0);
        drive(1'b1, 12'hFE1); lit("slt",    4'h1, 1, 0, 0, 0, 0);
        drive(1'b1, 12'hE00); lit("dec",    4'hF, 1, 1, 0, 1, 0);
        drive(1'b0, 12'h123); lit("hold1",  4'hF, 0, 1, 0, 1, 0);
        drive(1'b0, 12'h0F0); lit("hold2",  4'hF, 0, 1, 0, 1, 0);

        drive(1'b1, 12'h071); lit("pre_rst", 4'h8, 1, 0, 0, 1, 1);
        rst_n = 1'b0;
        drive(1'b1, 12'h0FF); lit("mid_rst", 4'h0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        drive(1'b0, 12'h071); lit("no_stale1", 4'h0, 0, 0, 0, 0, 0);
        drive(1'b0, 12'h135); lit("no_stale2", 4'h0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(63) != 0);
            drive($urandom_range(3) != 0, 12'($urandom_range(4095)));
        end
        rst_n = 1'b1;
        drive(1'b0, 12'h000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
